// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe
// Registered immediate-extension stage between decode and execute.
// Decodes the 24-bit instruction immediate into a DW-bit operand. The
// result is held in a one-entry output register backed by a one-entry skid
// register, so execute back-pressure never reaches decode combinationally.
module imm_extend_pipe #(
    parameter int DW       = 32,
    parameter int BR_SHIFT = 2,
    parameter bit ROT_EN   = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [23:0]   in_imm,
    input  logic [2:0]    ImmSrc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] ExtImm,
    output logic          out_err
);

    // Extension mode encodings carried by ImmSrc
    localparam logic [2:0] MODE_IMM8   = 3'b000;
    localparam logic [2:0] MODE_IMM12  = 3'b001;
    localparam logic [2:0] MODE_BRANCH = 3'b010;
    localparam logic [2:0] MODE_ROT8   = 3'b011;
    localparam logic [2:0] MODE_UOFF   = 3'b100;

    // Decoded operand for the entry currently on the input port
    logic [DW-1:0] decImm;
    logic          decErr;

    // Intermediate per-mode results
    logic [DW-1:0] zext8;
    logic [DW-1:0] zext12;
    logic [DW-1:0] signExt24;
    logic [DW-1:0] branchImm;
    logic [31:0]   rotBase;
    logic [5:0]    rotAmt;
    logic [31:0]   rot32;
    logic [DW-1:0] rotImm;
    logic [DW-1:0] offPos;
    logic [DW-1:0] offNeg;

    // Output register and skid register state
    logic          outValidQ, outValidD;
    logic [DW-1:0] outImmQ,   outImmD;
    logic          outErrQ,   outErrD;
    logic          skidValidQ, skidValidD;
    logic [DW-1:0] skidImmQ,   skidImmD;
    logic          skidErrQ,   skidErrD;
    logic          readyQ,     readyD;

    // Handshake events at the coming edge
    logic inFire;
    logic outFire;

    // Build every candidate operand; the rotation always works on 32 bits
    // and is widened or narrowed to DW afterwards.
    always_comb begin
        zext8     = DW'(in_imm[7:0]);
        zext12    = DW'(in_imm[11:0]);
        signExt24 = {{(DW-24){in_imm[23]}}, in_imm};
        branchImm = signExt24 << BR_SHIFT;
        rotBase   = {24'd0, in_imm[7:0]};
        rotAmt    = {1'b0, in_imm[11:8], 1'b0};
        rot32     = (rotBase >> rotAmt) | (rotBase << (6'd32 - rotAmt));
        rotImm    = DW'(rot32);
        offPos    = DW'(in_imm[11:0]);
        offNeg    = ~offPos + DW'(1);
    end

    // Select the operand for the requested mode; unknown modes yield zero
    // with the error flag raised.
    always_comb begin
        decImm = '0;
        decErr = 1'b0;
        case (ImmSrc)
            MODE_IMM8:   decImm = zext8;
            MODE_IMM12:  decImm = zext12;
            MODE_BRANCH: decImm = branchImm;
            MODE_ROT8: begin
                if (ROT_EN) begin
                    decImm = rotImm;
                end else begin
                    decErr = 1'b1;
                end
            end
            MODE_UOFF:   decImm = in_imm[23] ? offPos : offNeg;
            default:     decErr = 1'b1;
        endcase
    end

    // Handshake qualification; in_ready comes straight from a register so
    // out_ready never reaches it combinationally.
    always_comb begin
        inFire  = in_valid && readyQ;
        outFire = outValidQ && out_ready;
    end

    // Next-state for the two-entry buffer: flush wins, otherwise the output
    // refills from the skid first (FIFO order) and new entries go to the
    // output when it is free or to the skid when it is held.
    always_comb begin
        outValidD  = outValidQ;
        outImmD    = outImmQ;
        outErrD    = outErrQ;
        skidValidD = skidValidQ;
        skidImmD   = skidImmQ;
        skidErrD   = skidErrQ;

        if (flush) begin
            outValidD  = 1'b0;
            skidValidD = 1'b0;
        end else if (!outValidQ || outFire) begin
            if (skidValidQ) begin
                outValidD  = 1'b1;
                outImmD    = skidImmQ;
                outErrD    = skidErrQ;
                skidValidD = inFire;
                if (inFire) begin
                    skidImmD = decImm;
                    skidErrD = decErr;
                end
            end else if (inFire) begin
                outValidD = 1'b1;
                outImmD   = decImm;
                outErrD   = decErr;
            end else begin
                outValidD = 1'b0;
            end
        end else if (inFire) begin
            skidValidD = 1'b1;
            skidImmD   = decImm;
            skidErrD   = decErr;
        end

        readyD = !skidValidD;
    end

    // Buffer registers; reset empties both entries and holds in_ready low
    // until the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outValidQ  <= 1'b0;
            outImmQ    <= '0;
            outErrQ    <= 1'b0;
            skidValidQ <= 1'b0;
            skidImmQ   <= '0;
            skidErrQ   <= 1'b0;
            readyQ     <= 1'b0;
        end else begin
            outValidQ  <= outValidD;
            outImmQ    <= outImmD;
            outErrQ    <= outErrD;
            skidValidQ <= skidValidD;
            skidImmQ   <= skidImmD;
            skidErrQ   <= skidErrD;
            readyQ     <= readyD;
        end
    end

    assign in_ready  = readyQ;
    assign out_valid = outValidQ;
    assign ExtImm    = outImmQ;
    assign out_err   = outErrQ;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe
// Randomized and directed bench for imm_extend_pipe. Expected results come
// from an arithmetic reference of the extension rules and a queue model of
// the buffered entries.
module tb_imm_extend_pipe;

    logic        clk;
    logic        reset_n;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [23:0] inImm;
    logic [2:0]  immSrc;
    logic        outValid;
    logic        outReady;
    logic [31:0] extImm;
    logic        outErr;

    logic        flush64;
    logic        inValid64;
    logic        inReady64;
    logic [23:0] inImm64;
    logic [2:0]  immSrc64;
    logic        outValid64;
    logic        outReady64;
    logic [63:0] extImm64;
    logic        outErr64;

    int checkCount;
    int passCount;

    logic [64:0] expQ[$];
    bit          modelOutOfReset;

    imm_extend_pipe #(.DW(32), .BR_SHIFT(2), .ROT_EN(1'b1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_imm    (inImm),
        .ImmSrc    (immSrc),
        .out_valid (outValid),
        .out_ready (outReady),
        .ExtImm    (extImm),
        .out_err   (outErr)
    );

    imm_extend_pipe #(.DW(64), .BR_SHIFT(0), .ROT_EN(1'b0)) dut64 (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush64),
        .in_valid  (inValid64),
        .in_ready  (inReady64),
        .in_imm    (inImm64),
        .ImmSrc    (immSrc64),
        .out_valid (outValid64),
        .out_ready (outReady64),
        .ExtImm    (extImm64),
        .out_err   (outErr64)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Reference extension: returns {err, value} using plain integer arithmetic
    function automatic logic [64:0] refExt(input logic [23:0] imm, input logic [2:0] src,
                                           input int dw, input int brShift, input bit rotEn);
        longint unsigned mask;
        longint unsigned v;
        longint unsigned b;
        longint          s;
        int              r;
        bit              err;
        mask = (dw >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << dw) - 64'd1);
        err  = 1'b0;
        v    = 64'd0;
        case (src)
            3'd0: v = 64'(imm[7:0]);
            3'd1: v = 64'(imm[11:0]);
            3'd2: begin
                s = imm[23] ? (longint'(imm) - 64'sd16777216) : longint'(imm);
                s = s * (64'sd1 << brShift);
                v = 64'(s);
            end
            3'd3: begin
                if (rotEn) begin
                    b = 64'(imm[7:0]);
                    r = 2 * int'(imm[11:8]);
                    v = ((b >> r) | (b << (32 - r))) & 64'hFFFF_FFFF;
                end else begin
                    err = 1'b1;
                end
            end
            3'd4: begin
                b = 64'(imm[11:0]);
                v = imm[23] ? b : (64'd0 - b);
            end
            default: err = 1'b1;
        endcase
        return {err, v & mask};
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            passCount++;
        end
    endtask

    // One clock of the 32-bit instance: compare against the queue model at
    // the falling edge, then advance the model across the rising edge.
    task automatic applyStimulus();
        bit          expReady;
        bit          expValid;
        bit          inFire;
        bit          outFire;
        logic [64:0] e;
        expReady = modelOutOfReset && reset_n && (expQ.size() < 2);
        expValid = reset_n && (expQ.size() > 0);
        checkOutput("in_ready", 64'(inReady), 64'(expReady));
        checkOutput("out_valid", 64'(outValid), 64'(expValid));
        if (expValid) begin
            checkOutput("ext_imm", 64'(extImm), expQ[0][63:0]);
            checkOutput("out_err", 64'(outErr), 64'(expQ[0][64]));
        end
        inFire  = inValid && expReady;
        outFire = expValid && outReady;
        e       = refExt(inImm, immSrc, 32, 2, 1'b1);
        @(posedge clk);
        if (!reset_n) begin
            expQ.delete();
            modelOutOfReset = 1'b0;
        end else begin
            modelOutOfReset = 1'b1;
            if (flush) begin
                expQ.delete();
            end else begin
                if (outFire) void'(expQ.pop_front());
                if (inFire) expQ.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    logic [23:0] sweepImm [7];
    logic [2:0]  sweepSrc [7];
    logic [31:0] sweepExp [7];
    logic        sweepErr [7];
    logic [64:0] e64;

    initial begin
        clk = 1'b0; reset_n = 1'b0; flush = 1'b0; inValid = 1'b0;
        inImm = '0; immSrc = '0; outReady = 1'b0;
        flush64 = 1'b0; inValid64 = 1'b0; inImm64 = '0; immSrc64 = '0; outReady64 = 1'b1;
        checkCount = 0; passCount = 0; modelOutOfReset = 1'b0;

        sweepImm[0] = 24'h1234AB; sweepSrc[0] = 3'b000; sweepExp[0] = 32'h000000AB; sweepErr[0] = 1'b0;
        sweepImm[1] = 24'h123FFF; sweepSrc[1] = 3'b001; sweepExp[1] = 32'h00000FFF; sweepErr[1] = 1'b0;
        sweepImm[2] = 24'h800000; sweepSrc[2] = 3'b010; sweepExp[2] = 32'hFE000000; sweepErr[2] = 1'b0;
        sweepImm[3] = 24'h0004FF; sweepSrc[3] = 3'b011; sweepExp[3] = 32'hFF000000; sweepErr[3] = 1'b0;
        sweepImm[4] = 24'h000004; sweepSrc[4] = 3'b100; sweepExp[4] = 32'hFFFFFFFC; sweepErr[4] = 1'b0;
        sweepImm[5] = 24'h800004; sweepSrc[5] = 3'b100; sweepExp[5] = 32'h00000004; sweepErr[5] = 1'b0;
        sweepImm[6] = 24'h123456; sweepSrc[6] = 3'b111; sweepExp[6] = 32'h00000000; sweepErr[6] = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(outValid), 64'd0);
        checkOutput("rst_ext_imm", 64'(extImm), 64'd0);
        checkOutput("rst_out_err", 64'(outErr), 64'd0);
        checkOutput("rst_in_ready", 64'(inReady), 64'd0);
        reset_n = 1'b1;
        applyStimulus();
        checkOutput("ready_after_rst", 64'(inReady), 64'd1);

        // Mode sweep, one input per cycle, each result one cycle later
        outReady = 1'b1;
        for (int i = 0; i < 7; i++) begin
            inValid = 1'b1; inImm = sweepImm[i]; immSrc = sweepSrc[i];
            applyStimulus();
            checkOutput("sweep_val", 64'(extImm), 64'(sweepExp[i]));
            checkOutput("sweep_err", 64'(outErr), 64'(sweepErr[i]));
        end
        inValid = 1'b0;
        applyStimulus();

        // Back-pressure with three inputs A, B, C
        outReady = 1'b0;
        inValid = 1'b1; inImm = 24'h0000A1; immSrc = 3'b000;
        applyStimulus();
        inImm = 24'h000B22; immSrc = 3'b001;
        applyStimulus();
        checkOutput("bp_ready_after_b", 64'(inReady), 64'd0);
        inImm = 24'h0000C3; immSrc = 3'b000;
        applyStimulus();
        applyStimulus();
        checkOutput("bp_hold_a", 64'(extImm), 64'h0000_00A1);
        outReady = 1'b1;
        applyStimulus();
        applyStimulus();
        inValid = 1'b0;
        applyStimulus();
        checkOutput("bp_drained", 64'(outValid), 64'd0);

        // One entry held, then simultaneous transfers every cycle
        outReady = 1'b0;
        inValid = 1'b1; inImm = 24'($urandom); immSrc = 3'($urandom_range(0, 4));
        applyStimulus();
        outReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            inImm = 24'($urandom); immSrc = 3'($urandom_range(0, 4));
            applyStimulus();
            checkOutput("sim_ready", 64'(inReady), 64'd1);
            checkOutput("sim_valid", 64'(outValid), 64'd1);
        end
        inValid = 1'b0;
        applyStimulus();
        applyStimulus();

        // Flush with both entries full and an input presented
        outReady = 1'b0;
        inValid = 1'b1; inImm = 24'h000111; immSrc = 3'b001;
        applyStimulus();
        inImm = 24'h000222;
        applyStimulus();
        inImm = 24'h000333; flush = 1'b1;
        applyStimulus();
        flush = 1'b0; inValid = 1'b0;
        checkOutput("flush_valid", 64'(outValid), 64'd0);
        checkOutput("flush_ready", 64'(inReady), 64'd1);
        outReady = 1'b1;
        applyStimulus();
        applyStimulus();

        // Reset asserted mid-stall
        outReady = 1'b0;
        inValid = 1'b1; inImm = 24'h000044; immSrc = 3'b000;
        applyStimulus();
        inImm = 24'h000055;
        applyStimulus();
        inValid = 1'b0;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(outValid), 64'd0);
        checkOutput("mid_rst_ext", 64'(extImm), 64'd0);
        checkOutput("mid_rst_err", 64'(outErr), 64'd0);
        expQ.delete();
        modelOutOfReset = 1'b0;
        @(negedge clk);
        applyStimulus();
        reset_n = 1'b1;
        applyStimulus();
        outReady = 1'b1;
        inValid = 1'b1; inImm = 24'h123FFF; immSrc = 3'b001;
        applyStimulus();
        inValid = 1'b0;
        checkOutput("post_rst_val", 64'(extImm), 64'h0000_0FFF);
        applyStimulus();

        // Randomized traffic including flushes and illegal modes
        for (int i = 0; i < 400; i++) begin
            inValid  = 1'($urandom_range(0, 1));
            outReady = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 24) == 0);
            inImm    = 24'($urandom);
            immSrc   = 3'($urandom_range(0, 7));
            applyStimulus();
        end
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        repeat (3) applyStimulus();

        // Wide instance: DW=64, BR_SHIFT=0, ROT_EN=0
        inValid64 = 1'b1; inImm64 = 24'h800000; immSrc64 = 3'b010;
        @(posedge clk); @(negedge clk);
        inValid64 = 1'b0;
        checkOutput("w64_br_valid", 64'(outValid64), 64'd1);
        checkOutput("w64_br_val", extImm64, 64'hFFFF_FFFF_FF80_0000);
        checkOutput("w64_br_err", 64'(outErr64), 64'd0);
        inValid64 = 1'b1; inImm64 = 24'h0004FF; immSrc64 = 3'b011;
        @(posedge clk); @(negedge clk);
        inValid64 = 1'b0;
        checkOutput("w64_rot_err", 64'(outErr64), 64'd1);
        checkOutput("w64_rot_val", extImm64, 64'd0);
        for (int i = 0; i < 30; i++) begin
            inValid64 = 1'b1; inImm64 = 24'($urandom); immSrc64 = 3'($urandom_range(0, 7));
            e64 = refExt(inImm64, immSrc64, 64, 0, 1'b0);
            @(posedge clk); @(negedge clk);
            checkOutput("w64_rand_val", extImm64, e64[63:0]);
            checkOutput("w64_rand_err", 64'(outErr64), 64'(e64[64]));
        end
        inValid64 = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
